// File: rtl/side_road_detector_pkg.sv
// side_road_detector_pkg: shared light codes, detector state encoding and queue width
package side_road_detector_pkg;
  localparam int QW = 8;
  typedef logic [QW-1:0] queue_t;
  localparam logic [3:0] LIGHT_GREEN  = 4'b0001;
  localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
  localparam logic [3:0] LIGHT_RED    = 4'b0100;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALL   = 2'd1;
  localparam logic [1:0] ST_SERVE  = 2'd2;
  localparam logic [1:0] ST_GAPOUT = 2'd3;
endpackage

// File: rtl/side_road_detector_loop_debounce.sv
// loop_debounce: 2-flop synchronizer, debounce filter and registered rising-edge pulse
module loop_debounce #(
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1_q, s2_q, level_q, level_d, rise_q, rise_d, hit;
  logic [CW-1:0] cnt_q, cnt_d, cnt_n;
  always_comb begin
    cnt_n = (s2_q != level_q) ? cnt_q + 1'b1 : '0;
    hit = cnt_n == CW'(DEBOUNCE_CYC);
    cnt_d = hit ? '0 : cnt_n;
    level_d = hit ? s2_q : level_q;
    rise_d = level_d & ~level_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      level_q <= level_d;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/side_road_detector.sv
// side_road_detector: side-road vehicle queue tracking and demand FSM for a traffic light controller
module side_road_detector
  import side_road_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 3,
  parameter int CALL_THRESH  = 1,
  parameter int GAP_CYC      = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arrive_raw,
  input  logic          depart_raw,
  input  logic [3:0]    side_road_light,
  output logic          SENSOR,
  output logic [QW-1:0] queue_count,
  output logic          light_fault
);
  localparam int GW = $clog2(GAP_CYC + 1);
  logic arr_rise, dep_rise, green, go, inc, dec;
  logic sensor_q, sensor_d, fault_q, fault_d;
  logic [1:0] state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  queue_t queue_q, queue_d;
  loop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arrive (
    .clk(clk), .rst(rst), .raw(arrive_raw), .rise(arr_rise)
  );
  loop_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_depart (
    .clk(clk), .rst(rst), .raw(depart_raw), .rise(dep_rise)
  );
  always_comb begin
    green = side_road_light == LIGHT_GREEN;
    go = green || side_road_light == LIGHT_YELLOW;
    fault_d = !go && side_road_light != LIGHT_RED;
    inc = arr_rise;
    dec = dep_rise & go;
    gap_d = (state_q != ST_SERVE || dec) ? '0 : gap_q + 1'b1;
    state_d = state_q == ST_IDLE  ? (queue_q >= QW'(CALL_THRESH) ? ST_CALL : ST_IDLE)
            : state_q == ST_CALL  ? (queue_q == '0 ? ST_IDLE : green ? ST_SERVE : ST_CALL)
            : state_q == ST_SERVE ? (queue_q == '0 ? ST_IDLE : !go ? ST_CALL
                                    : (!dec && gap_q == GW'(GAP_CYC - 1)) ? ST_GAPOUT : ST_SERVE)
            : ST_IDLE;
    queue_d = (state_q == ST_GAPOUT || state_d == ST_GAPOUT) ? '0
            : (inc && !dec && queue_q != '1) ? queue_q + 1'b1
            : (dec && !inc && queue_q != '0) ? queue_q - 1'b1
            : queue_q;
    sensor_d = state_d == ST_CALL || state_d == ST_SERVE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q <= '0;
      queue_q <= '0;
      sensor_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      queue_q <= queue_d;
      sensor_q <= sensor_d;
      fault_q <= fault_d;
    end
  end
  assign SENSOR = sensor_q;
  assign queue_count = queue_q;
  assign light_fault = fault_q;
endmodule

// File: tb/tb_side_road_detector.sv
// tb_side_road_detector: directed table-driven and sequence checks for side_road_detector
module tb_side_road_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arrive_raw = 1'b0;
  logic depart_raw = 1'b0;
  logic [3:0] side_road_light = 4'b0000;
  logic SENSOR;
  logic [7:0] queue_count;
  logic light_fault;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic arr;
    logic dep;
    logic [3:0] light;
    logic [7:0] q;
    logic s;
    logic f;
  } vec_t;
  vec_t vecs[19];
  side_road_detector dut (
    .clk(clk), .rst(rst), .arrive_raw(arrive_raw), .depart_raw(depart_raw),
    .side_road_light(side_road_light), .SENSOR(SENSOR),
    .queue_count(queue_count), .light_fault(light_fault)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse_arrive();
    arrive_raw = 1'b1;
    tick(8);
    arrive_raw = 1'b0;
    tick(8);
  endtask
  task automatic pulse_depart();
    depart_raw = 1'b1;
    tick(8);
    depart_raw = 1'b0;
    tick(8);
  endtask
  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 14; i++) begin
      vecs[i].arr = i < 10;
      vecs[i].dep = 1'b0;
      vecs[i].light = 4'b0100;
      vecs[i].q = (i + 1 >= 6) ? 8'd1 : 8'd0;
      vecs[i].s = i + 1 >= 7;
      vecs[i].f = 1'b0;
    end
    vecs[14] = '{1'b0, 1'b0, 4'b0011, 8'd1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 4'b1000, 8'd1, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 4'b0000, 8'd1, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 4'b0100, 8'd1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 4'b0010, 8'd1, 1'b1, 1'b0};
    tick(3);
    check("reset_queue", queue_count, 0);
    check("reset_sensor", SENSOR, 0);
    check("reset_fault", light_fault, 0);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      arrive_raw = vecs[i].arr;
      depart_raw = vecs[i].dep;
      side_road_light = vecs[i].light;
      tick(1);
      check($sformatf("vec%0d_queue", i), queue_count, vecs[i].q);
      check($sformatf("vec%0d_sensor", i), SENSOR, vecs[i].s);
      check($sformatf("vec%0d_fault", i), light_fault, vecs[i].f);
    end
    side_road_light = 4'b0011;
    pulse_depart();
    check("illegal_dep_queue", queue_count, 1);
    check("illegal_dep_fault", light_fault, 1);
    side_road_light = 4'b0100;
    pulse_arrive();
    pulse_arrive();
    check("q3_queue", queue_count, 3);
    check("q3_sensor", SENSOR, 1);
    side_road_light = 4'b0001;
    tick(1);
    pulse_depart();
    check("dep1_queue", queue_count, 2);
    pulse_depart();
    check("dep2_queue", queue_count, 1);
    depart_raw = 1'b1;
    tick(6);
    check("dep3_queue", queue_count, 0);
    check("dep3_sensor_hold", SENSOR, 1);
    tick(1);
    check("dep3_sensor_fall", SENSOR, 0);
    tick(1);
    depart_raw = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      arrive_raw = 1'b1;
      tick(2);
      arrive_raw = 1'b0;
      tick(2);
    end
    tick(8);
    check("glitch_queue", queue_count, 0);
    check("glitch_sensor", SENSOR, 0);
    side_road_light = 4'b0100;
    pulse_arrive();
    pulse_arrive();
    check("gap_q2", queue_count, 2);
    side_road_light = 4'b0001;
    tick(20);
    check("gap_serve_sensor", SENSOR, 1);
    check("gap_serve_queue", queue_count, 2);
    tick(1);
    check("gapout_sensor", SENSOR, 0);
    check("gapout_queue", queue_count, 0);
    tick(1);
    check("gap_idle_sensor", SENSOR, 0);
    check("gap_idle_queue", queue_count, 0);
    tick(3);
    check("gap_idle_sensor_late", SENSOR, 0);
    pulse_depart();
    check("sat_zero_queue", queue_count, 0);
    side_road_light = 4'b0100;
    repeat (5) pulse_arrive();
    check("q5_queue", queue_count, 5);
    side_road_light = 4'b0010;
    arrive_raw = 1'b1;
    depart_raw = 1'b1;
    tick(8);
    arrive_raw = 1'b0;
    depart_raw = 1'b0;
    tick(8);
    check("simul_queue", queue_count, 5);
    check("simul_sensor", SENSOR, 1);
    pulse_depart();
    check("yellow_dep_queue", queue_count, 4);
    side_road_light = 4'b0100;
    repeat (251) pulse_arrive();
    check("q255_queue", queue_count, 255);
    pulse_arrive();
    check("sat_255_queue", queue_count, 255);
    side_road_light = 4'b0001;
    tick(3);
    check("serve255_sensor", SENSOR, 1);
    check("serve255_queue", queue_count, 255);
    rst = 1'b1;
    side_road_light = 4'b0011;
    tick(1);
    check("midrst_queue", queue_count, 0);
    check("midrst_sensor", SENSOR, 0);
    check("midrst_fault", light_fault, 0);
    rst = 1'b0;
    side_road_light = 4'b0001;
    tick(5);
    check("postrst_queue", queue_count, 0);
    check("postrst_sensor", SENSOR, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/side_road_detector.md
SIDE_ROAD_DETECTOR -- requirements
Module: side_road_detector

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 3: consecutive stable cycles required before a filtered loop level changes.
REQ-002 Parameter CALL_THRESH, default 1: queue depth at or above which a call is raised.
REQ-003 Parameter GAP_CYC, default 20: cycles without a departure during service before gap-out.
REQ-004 Port clk, input, 1: single clock, all logic on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port arrive_raw, input, 1: asynchronous advance-loop detector, 1 = vehicle present.
REQ-007 Port depart_raw, input, 1: asynchronous stop-line loop detector, 1 = vehicle present.
REQ-008 Port side_road_light, input, 4: side road lamp code; 4'b0001 green, 4'b0010 yellow, 4'b0100 red.
REQ-009 Port SENSOR, output, 1: registered side-road demand to the traffic light controller.
REQ-010 Port queue_count, output, 8: registered count of vehicles waiting.
REQ-011 Port light_fault, output, 1: registered, high while side_road_light is not one of the three legal codes.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchronizer, then a debounce counter; the filtered level SHALL change only after DEBOUNCE_CYC consecutive synchronized samples differ from it.
REQ-013 Raw-to-filtered latency SHALL be exactly 2 + DEBOUNCE_CYC cycles for a clean step.
REQ-014 A rising edge of filtered arrive SHALL be one arrival event; a rising edge of filtered depart SHALL be one departure event.
REQ-015 Departures SHALL count only while side_road_light is green or yellow; a departure on red or on an illegal code SHALL be ignored.
REQ-016 queue_count SHALL update the cycle after the event: +1 on arrival, -1 on counted departure, unchanged when both occur in the same cycle.
REQ-017 queue_count SHALL saturate at 255 on arrival and at 0 on departure, with no wrap-around.
REQ-018 Illegal light codes (zero, multi-hot, bit 3 set) SHALL be treated as red and SHALL assert light_fault the next cycle.
REQ-019 State IDLE, SENSOR=0: go to CALL when queue_count >= CALL_THRESH.
REQ-020 State CALL, SENSOR=1: go to SERVE when the light is green; go to IDLE if queue_count drops to 0.
REQ-021 State SERVE, SENSOR=1, gap timer runs: go to IDLE when queue_count reaches 0; go to GAPOUT when the gap timer reaches GAP_CYC.
REQ-022 The gap timer SHALL clear on entering SERVE and on every counted departure.
REQ-023 State GAPOUT, SENSOR=0: clear queue_count to 0 for one cycle, then go to IDLE; arrivals in that cycle SHALL be lost.
REQ-024 SENSOR SHALL be a registered decode of the state; it SHALL not glitch within a state.
REQ-025 If the light turns red while in SERVE with queue_count > 0, the block SHALL return to CALL.

Reset
REQ-026 While rst is high: state IDLE, SENSOR=0, queue_count=0, light_fault=0, filtered levels 0, debounce and gap counters 0, synchronizers 0.
REQ-027 Reset asserted mid-service SHALL discard the queue; no event SHALL be counted in the first cycle after reset.

Structure
REQ-028 The shared package SHALL hold the light-code constants (GREEN/YELLOW/RED), the detector state encoding, and the queue width.
REQ-029 One sub-module, loop_debounce (synchronizer, debounce and rising-edge pulse), SHALL be instantiated twice.

Verification
REQ-030 rst, then arrive_raw high for 10 cycles with light red -> queue_count=1 and SENSOR=1 at cycle 6/7 after the edge, state CALL.
REQ-031 Queue 3, light green, three clean depart pulses -> queue_count 3->2->1->0, SENSOR falls the cycle after 0.
REQ-032 arrive_raw toggled for 2-cycle glitches (DEBOUNCE_CYC=3) -> no count change, SENSOR stays 0.
REQ-033 Queue 2, light green, no departures for 20 cycles -> GAPOUT, SENSOR=0, queue_count=0, then IDLE.
REQ-034 Queue at 255 plus an arrival -> stays 255; queue 0 plus a departure on green -> stays 0; simultaneous arrival and departure at queue 5 -> stays 5.
REQ-035 side_road_light=4'b0011 with a depart pulse -> light_fault=1, queue unchanged; rst mid-SERVE -> all outputs 0 next cycle.
